// File: rtl/conv_pkg.sv
// Shared constants and collector state encoding for the convolution pipeline.
// Control path, datapath and output collector all size themselves from here.
// No logic; types and parameters only.
package conv_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int IMAGE_SIZE  = 28;
  localparam int KERNEL_SIZE = 5;
  localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int ADDR_W      = $clog2(OUT_SIZE * OUT_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW     = 2'd1,
    ROW_GAP = 2'd2
  } coll_state_t;

endpackage

// File: rtl/conv_output_collector.sv
// Places each convolver result at its (row, col) slot of the output map, optional ReLU.
// Latency: 1 cycle from accepting edge to registered write strobe/address/data.
// No backpressure: every cycle with in_valid high is written; gaps only flag errors mid-row.
module conv_output_collector #(
  parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int IMAGE_SIZE  = conv_pkg::IMAGE_SIZE,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter bit RELU_EN     = 1'b1,
  localparam int OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int ADDR_W     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE * OUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  row_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_short_row
);

  import conv_pkg::*;

  localparam int RC_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [RC_W-1:0]   LAST_RC   = RC_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_SIZE * OUT_SIZE - 1);

  coll_state_t         state;
  logic [RC_W-1:0]     row;
  logic [RC_W-1:0]     col;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_WIDTH-1:0] relu_data;

  // Clamp negative results to zero when ReLU is enabled.
  always_comb begin
    relu_data = in_data;
    if (RELU_EN && in_data[DATA_WIDTH-1]) relu_data = '0;
  end

  // busy follows the registered state directly, so it is glitch-free.
  assign busy = (state != IDLE);

  // Collector FSM: position counters, registered write port, boundary pulses, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      addr          <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      row_done      <= 1'b0;
      frame_done    <= 1'b0;
      err_short_row <= 1'b0;
    end else begin
      wr_en      <= in_valid;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      // Clear first so that a same-cycle error below takes priority.
      if (err_clr) err_short_row <= 1'b0;

      if (in_valid) begin
        wr_addr <= addr;
        wr_data <= relu_data;
        addr    <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        // IDLE and ROW_GAP always sit at col 0, so one end-of-row test covers all states
        // (including a degenerate 1-wide map, where the first sample also ends the row).
        if (col == LAST_RC) begin
          row_done <= 1'b1;
          col      <= '0;
          if (row == LAST_RC) begin
            frame_done <= 1'b1;
            row        <= '0;
            state      <= IDLE;
          end else begin
            row   <= row + 1'b1;
            state <= ROW_GAP;
          end
        end else begin
          col   <= col + 1'b1;
          state <= ROW;
        end
      end else if (state == ROW && col != '0) begin
        // Row interrupted: keep position so the next valid resumes at the same col.
        err_short_row <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
module tb_conv_output_collector;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int OS   = 24;
  localparam int NPIX = OS * OS;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          err_clr;

  logic          wr_en, row_done, frame_done, busy, err_short_row;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          n_wr_en, n_row_done, n_frame_done, n_busy, n_err_short_row;
  logic [AW-1:0] n_wr_addr;
  logic [DW-1:0] n_wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_output_collector #(.RELU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_done(row_done),
    .frame_done(frame_done), .busy(busy), .err_short_row(err_short_row)
  );

  conv_output_collector #(.RELU_EN(1'b0)) dut_norelu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data), .row_done(n_row_done),
    .frame_done(n_frame_done), .busy(n_busy), .err_short_row(n_err_short_row)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_en, wr_addr, wr_data, row_done, frame_done, busy, err_short_row} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h rd=%b fd=%b busy=%b err=%b, want all 0",
               wr_en, wr_addr, wr_data, row_done, frame_done, busy, err_short_row);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_write: wr_en=%b want 0", wr_en);
    end
  endtask

  task automatic test_nominal_frame();
    int idx = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    do_reset();
    for (int r = 0; r < OS; r++) begin
      for (int c = 0; c < OS; c++) begin
        in_valid = 1'b1;
        in_data  = DW'(idx);
        step();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== AW'(idx) || wr_data !== DW'(idx)
            || row_done !== (c == OS - 1) || frame_done !== (idx == NPIX - 1)) begin
          errors++;
          $display("FAIL nominal_write[%0d]: en=%b addr=%0d data=%0d rd=%b fd=%b, want en=1 addr=%0d data=%0d rd=%b fd=%b",
                   idx, wr_en, wr_addr, wr_data, row_done, frame_done, idx, idx, (c == OS - 1), (idx == NPIX - 1));
        end
        if (row_done === 1'b1) rd_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        idx++;
      end
      if (r == 5) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL nominal_busy_mid: busy=%b want 1", busy);
        end
      end
      if (r != OS - 1) begin
        for (int g = 0; g < 4; g++) begin
          in_valid = 1'b0;
          step();
          checks++;
          if (wr_en !== 1'b0 || row_done !== 1'b0 || err_short_row !== 1'b0) begin
            errors++;
            $display("FAIL nominal_gap: en=%b rd=%b err=%b want 0 0 0", wr_en, row_done, err_short_row);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rd_cnt != OS || fd_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_totals: row_done=%0d frame_done=%0d busy=%b, want 24 1 0", rd_cnt, fd_cnt, busy);
    end
  endtask

  task automatic test_relu();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'hFFF6;
    step();
    checks++;
    if (wr_data !== 16'h0000 || n_wr_data !== 16'hFFF6) begin
      errors++;
      $display("FAIL relu_negative: relu=%h norelu=%h, want 0000 fff6", wr_data, n_wr_data);
    end
    in_data = 16'h0007;
    step();
    checks++;
    if (wr_data !== 16'h0007 || n_wr_data !== 16'h0007 || wr_addr !== AW'(1)) begin
      errors++;
      $display("FAIL relu_positive: relu=%h norelu=%h addr=%0d, want 0007 0007 1", wr_data, n_wr_data, wr_addr);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_short_row();
    int fd_at = -1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (err_short_row !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL short_row_flag: err=%b en=%b, want 1 0", err_short_row, wr_en);
    end
    step();
    for (int i = 10; i < NPIX; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      if (i == 10) begin
        checks++;
        if (wr_addr !== AW'(10) || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL short_row_resume: addr=%0d en=%b, want 10 1", wr_addr, wr_en);
        end
      end
      if (frame_done === 1'b1) fd_at = int'(wr_addr);
    end
    in_valid = 1'b0;
    checks++;
    if (fd_at != NPIX - 1 || err_short_row !== 1'b1) begin
      errors++;
      $display("FAIL short_row_frame: frame_done addr=%0d err=%b, want 575 1", fd_at, err_short_row);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_short_row !== 1'b0) begin
      errors++;
      $display("FAIL short_row_clear: err=%b want 0", err_short_row);
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 2 * NPIX; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      if (i == NPIX) begin
        checks++;
        if (wr_addr !== '0 || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart: addr=%0d en=%b, want 0 1", wr_addr, wr_en);
        end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        checks++;
        if (i != NPIX - 1 && i != 2 * NPIX - 1) begin
          errors++;
          $display("FAIL b2b_frame_done_pos: at write %0d, want 575 or 1151", i);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (fd_cnt != 2 || err_short_row !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: frame_done=%0d err=%b, want 2 0", fd_cnt, err_short_row);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 1);
      step();
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, row_done, frame_done, busy, err_short_row} !== '0) begin
      errors++;
      $display("FAIL async_reset: en=%b addr=%0d data=%h busy=%b, want all 0", wr_en, wr_addr, wr_data, busy);
    end
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < NPIX - 300; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      if (i == 0) begin
        checks++;
        if (wr_addr !== '0 || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL reset_restart: addr=%0d en=%b, want 0 1", wr_addr, wr_en);
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (fd_cnt != 0 || wr_addr !== AW'(NPIX - 301)) begin
      errors++;
      $display("FAIL aborted_frame: frame_done=%0d last addr=%0d, want 0 275", fd_cnt, wr_addr);
    end
  endtask

  task automatic test_err_clr_collision();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
    end
    in_valid = 1'b0;
    err_clr  = 1'b1;
    step();
    checks++;
    if (err_short_row !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_set: err=%b want 1", err_short_row);
    end
    in_valid = 1'b1;
    in_data  = 16'd5;
    step();
    err_clr  = 1'b0;
    checks++;
    if (err_short_row !== 1'b0 || wr_addr !== AW'(5)) begin
      errors++;
      $display("FAIL clr_keeps_position: err=%b addr=%0d, want 0 5", err_short_row, wr_addr);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    test_reset();
    test_nominal_frame();
    test_relu();
    test_short_row();
    test_back_to_back();
    test_reset_mid_frame();
    test_err_clr_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_output_collector.md
Name: conv_output_collector

Overview:
- Receives the valid-qualified result stream from the convolver datapath.
- Input is `in_valid` (the control-path enable) plus `in_data`.
- Assigns each result its (row, col) position in the OUT_SIZE x OUT_SIZE feature map, optionally applies ReLU, and writes it to the feature-map buffer through a registered write port.
- Flags row/frame boundaries and protocol violations, closing the loop on the enable-generating control path.

Parameters:
- DATA_WIDTH, 16, width of signed two's-complement convolution result.
- IMAGE_SIZE, 28, input image side length.
- KERNEL_SIZE, 5, kernel side length.
- RELU_EN, 1, 1 = clamp negative results to 0 before write; 0 = pass-through.
- OUT_SIZE (localparam), IMAGE_SIZE-KERNEL_SIZE+1 = 24, output map side.
- ADDR_W (localparam), clog2(OUT_SIZE*OUT_SIZE) = 10, buffer address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  result valid (convolver enable).
- in_data  in  DATA_WIDTH  convolution result, signed.
- err_clr  in  1  synchronous clear of sticky error flags.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer address = row*OUT_SIZE+col.
- wr_data  out  DATA_WIDTH  result after optional ReLU.
- row_done  out  1  one-cycle pulse with write of col OUT_SIZE-1.
- frame_done  out  1  one-cycle pulse with write of addr OUT_SIZE*OUT_SIZE-1.
- busy  out  1  high while a frame is in progress (state != IDLE).
- err_short_row  out  1  sticky: in_valid dropped mid-row.

Behaviour:
- Reset is asynchronous and active-high; reset reset, clock clk.
- Reset values: all outputs 0; state IDLE; row=0, col=0, addr counter=0.
- Latency is 1 cycle. A sample accepted at edge N (in_valid=1) appears on wr_en/wr_addr/wr_data in the cycle after edge N.
- wr_en is low in every cycle with no accepted sample.
- There is no backpressure: every cycle with in_valid=1 is accepted and written.
- Address generation: an incrementing counter, no multiplier.
  - The counter advances by 1 per accepted sample.
  - It wraps to 0 after OUT_SIZE*OUT_SIZE-1.
- ReLU: if RELU_EN=1 and in_data[DATA_WIDTH-1]=1, wr_data=0; otherwise wr_data=in_data.
- FSM states:
  - IDLE: no frame active. in_valid=1 writes addr 0 and moves to ROW (col->1). If OUT_SIZE==1, treat as end of row immediately.
  - ROW: accepting a row.
    - in_valid=1 writes at the current col; col++.
    - At col==OUT_SIZE-1: assert row_done, col->0, row++.
      - If row==OUT_SIZE-1: assert frame_done, row->0, go to IDLE.
      - Otherwise go to ROW_GAP.
    - in_valid=0 with col!=0: set err_short_row; stay in ROW (the next valid continues at the same col).
  - ROW_GAP: between rows. in_valid=1 writes col 0 of the next row and moves to ROW. A gap of any length is legal, including zero cycles.
- Boundary rules:
  - row_done and frame_done are asserted coincident with the corresponding wr_en.
  - frame_done coincides with the final row_done.
  - Back-to-back frames: a valid in the cycle after frame_done's accepting edge starts the next frame at addr 0.
  - err_clr and a new error in the same cycle: set wins.
  - err_clr does not affect state, row or col.
  - Reset mid-frame aborts the frame. The counter returns to 0 and the next valid writes addr 0. No frame_done is produced for the aborted frame.
  - No other X-propagation or overflow cases: row/col/addr are bounded by the wrap rules above.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_WIDTH, IMAGE_SIZE, KERNEL_SIZE;
  - derived OUT_SIZE and ADDR_W;
  - the collector FSM state encoding (IDLE=2'd0, ROW=2'd1, ROW_GAP=2'd2).
- These are the same constants the control path and datapath use.
- No sub-module is required: FSM, row/col/addr counters, ReLU and output registers form one module.

Test Plan:
1. Nominal frame: 24 bursts of 24 consecutive valids, 4-cycle gaps between rows (data = index 0..575) -> 576 writes, wr_addr 0..575 in order, wr_data = index, 24 row_done pulses, one frame_done with addr 575, busy low after.
2. ReLU: RELU_EN=1, in_data=16'hFFF6 (-10) then 16'h0007 -> wr_data 0 then 7. With RELU_EN=0 -> 16'hFFF6 then 7.
3. Short row: in_valid drops for 2 cycles after 10 samples of row 0 -> err_short_row=1 (sticky). Next valid writes addr 10. Frame still completes at addr 575. err_clr -> flag 0.
4. Back-to-back frames with zero-length row gaps -> after frame_done, the next valid writes addr 0. A second frame_done occurs exactly 576 writes later.
5. Reset mid-frame: assert reset after 300 writes -> all outputs 0 asynchronously. After release, the next valid writes addr 0 and no frame_done is seen for the aborted frame.
6. Simultaneous err_clr with a mid-row drop of in_valid -> err_short_row remains 1.
